instr_sequencer: RTL and testbench

Instruction fetch sequencer for the 21-bit-word processor. Owns the program counter, drives the address of the asynchronous instruction ROM, and captures the returned word into an instruction register. Presents each instruction to the execute unit over a valid/ready handshake, applies branch redirects from the execute unit, and stops on a HALT opcode. Sits between the instruction ROM and the execute/control unit.

---
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Instruction fetch sequencer for the 21-bit-word processor. Owns the program
// counter, addresses the asynchronous instruction ROM, captures the returned
// word into the instruction register and offers it to the execute unit over a
// valid/ready handshake. Branch redirects from the execute unit reload the PC
// and refetch; a HALT opcode stops fetching until the next start pulse.
//
// Parameters
//   ROM_WIDTH     instruction word width (must be at least 4)
//   RESET_PC      PC value after reset and on start from IDLE
//   HALT_OPC      opcode (top three word bits) that halts fetch
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   pulse; leaves IDLE (from RESET_PC) or HALT (from pc)
//   rom_addr       out  ROM address, always equal to the pc register
//   rom_data       in   ROM word for rom_addr, valid in the same cycle
//   instr          out  instruction register
//   instr_valid    out  instr holds an unconsumed instruction
//   instr_ready    in   execute unit accepts instr this cycle
//   branch_valid   in   single-cycle redirect request
//   branch_target  in   redirect address
//   busy           out  sequencer is fetching or issuing
//   halted         out  sequencer stopped on a HALT word
//   instr_count    out  accepted-instruction count, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned ROM_WIDTH = 21,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [2:0]  HALT_OPC  = 3'b011
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [15:0]          rom_addr,
    input  logic [ROM_WIDTH-1:0] rom_data,
    output logic [ROM_WIDTH-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 branch_valid,
    input  logic [15:0]          branch_target,
    output logic                 busy,
    output logic                 halted,
    output logic [15:0]          instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            pc_q, pc_d;
    logic [ROM_WIDTH-1:0]   instr_q, instr_d;
    logic [15:0]            count_q, count_d;

    logic                   transfer;
    logic                   word_is_halt;
    logic [15:0]            pc_inc;

    // A transfer can only happen while an instruction is being presented.
    assign transfer     = (state_q == ST_ISSUE) && instr_ready;

    // The opcode lives in the top three bits of the word currently on the ROM.
    assign word_is_halt = (rom_data[ROM_WIDTH-1 -: 3] == HALT_OPC);

    // 16-bit add wraps naturally, so 16'hFFFF is followed by 16'h0000.
    assign pc_inc       = pc_q + 16'd1;

    // Next-state logic. Every fetch (first fetch after FETCH, or the refill
    // that follows an accepted instruction in ISSUE) captures rom_data and
    // advances the pc. A HALT word is still captured but never presented:
    // the machine goes straight to HALT with the pc already past it, so a
    // later start resumes with the following word. A branch overrides any
    // fetch in the same cycle and forces one FETCH cycle at the target.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (branch_valid) begin
                    // Word on rom_data is discarded; refetch from the target.
                    pc_d    = branch_target;
                    state_d = ST_FETCH;
                end else begin
                    instr_d = rom_data;
                    pc_d    = pc_inc;
                    state_d = word_is_halt ? ST_HALT : ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (branch_valid) begin
                    pc_d    = branch_target;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    instr_d = rom_data;
                    pc_d    = pc_inc;
                    state_d = word_is_halt ? ST_HALT : ST_ISSUE;
                end
            end

            ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Accepted-instruction counter. A transfer coinciding with a branch still
    // counts, so this only looks at the handshake, not at the next state.
    always_comb begin
        count_d = count_q;
        if (transfer && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // All outputs are decoded straight from registers.
    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer. Holds a 64K-word ROM image that
// drives rom_data combinationally from rom_addr, and a behavioural model of
// the sequencer described in terms of "running / presenting / stopped"
// rather than the design's states. Directed scenarios check fixed expected
// values; the randomized scenario compares every output to the model.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int unsigned ROM_WIDTH = 21;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [2:0]  HALT_OPC  = 3'b011;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [15:0]          rom_addr;
    logic [ROM_WIDTH-1:0] rom_data;
    logic [ROM_WIDTH-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 branch_valid;
    logic [15:0]          branch_target;
    logic                 busy;
    logic                 halted;
    logic [15:0]          instr_count;

    logic [ROM_WIDTH-1:0] rom [0:65535];

    int checks;
    int failures;

    // Reference model state.
    logic [15:0]          m_pc;
    logic [15:0]          m_count;
    logic [ROM_WIDTH-1:0] m_instr;
    logic                 m_running;
    logic                 m_valid;
    logic                 m_halted;

    instr_sequencer #(
        .ROM_WIDTH (ROM_WIDTH),
        .RESET_PC  (RESET_PC),
        .HALT_OPC  (HALT_OPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .busy          (busy),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    // Asynchronous ROM.
    assign rom_data = rom[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Random word whose opcode is never the halt opcode.
    function automatic logic [ROM_WIDTH-1:0] plain_word();
        logic [31:0]          r;
        logic [ROM_WIDTH-1:0] w;
        r = $urandom;
        w = r[ROM_WIDTH-1:0];
        if (w[ROM_WIDTH-1 -: 3] == HALT_OPC) w[ROM_WIDTH-1] = ~w[ROM_WIDTH-1];
        return w;
    endfunction

    function automatic logic [ROM_WIDTH-1:0] halt_word();
        logic [ROM_WIDTH-1:0] w;
        w = plain_word();
        w[ROM_WIDTH-1 -: 3] = HALT_OPC;
        return w;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 65536; i++) rom[i] = plain_word();
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_count   = 16'h0000;
        m_instr   = '0;
        m_running = 1'b0;
        m_valid   = 1'b0;
        m_halted  = 1'b0;
    endtask

    // One clock of the sequencer as described behaviourally: an accepted
    // instruction is counted; a stopped sequencer waits for start; a running
    // one either redirects or, whenever nothing is waiting to be accepted,
    // loads the next word and either offers it or stops on a halt opcode.
    task automatic model_step();
        logic                 accepted;
        logic [ROM_WIDTH-1:0] w;
        accepted = m_valid && instr_ready;
        if (accepted && m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (!m_running) begin
            if (start) begin
                if (!m_halted) m_pc = RESET_PC;
                m_running = 1'b1;
                m_halted  = 1'b0;
                m_valid   = 1'b0;
            end
        end else if (branch_valid) begin
            m_pc    = branch_target;
            m_valid = 1'b0;
        end else if (!m_valid || accepted) begin
            w       = rom[m_pc];
            m_instr = w;
            m_pc    = m_pc + 16'd1;
            if (w[ROM_WIDTH-1 -: 3] == HALT_OPC) begin
                m_running = 1'b0;
                m_halted  = 1'b1;
                m_valid   = 1'b0;
            end else begin
                m_valid = 1'b1;
            end
        end
    endtask

    // Advance one clock; outputs are observed 1 ns after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then start; returns with ROM[RESET_PC] being presented.
    task automatic reset_and_start();
        start         = 1'b0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        start = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0; branch_target = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (rom_addr !== RESET_PC) begin failures++; $display("[TB] FAIL reset_rom_addr: got %h expected %h", rom_addr, RESET_PC); end
        checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: got busy=%b valid=%b halted=%b expected 0/0/0", busy, instr_valid, halted); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_without_start: got busy=%b valid=%b expected 0/0", busy, instr_valid); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== RESET_PC) begin failures++; $display("[TB] FAIL start_fetch: got busy=%b valid=%b addr=%h expected 1/0/%h", busy, instr_valid, rom_addr, RESET_PC); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL start_latency: got valid=%b expected 1", instr_valid); end
        checks++; if (instr !== rom[0]) begin failures++; $display("[TB] FAIL start_instr: got %h expected %h", instr, rom[0]); end
        checks++; if (rom_addr !== 16'h0001) begin failures++; $display("[TB] FAIL start_pc: got %h expected %h", rom_addr, 16'h0001); end
        instr_ready = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b0;
        checks++; if (instr_count !== 16'd3) begin failures++; $display("[TB] FAIL pre_reset_count: got %0d expected 3", instr_count); end
        // Asynchronous reset in the middle of ISSUE.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (rom_addr !== RESET_PC || instr !== '0) begin failures++; $display("[TB] FAIL midreset_regs: got addr=%h instr=%h expected %h/0", rom_addr, instr, RESET_PC); end
        checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL midreset_flags: got valid=%b busy=%b halted=%b expected 0/0/0", instr_valid, busy, halted); end
        checks++; if (instr_count !== 16'h0000) begin failures++; $display("[TB] FAIL midreset_count: got %h expected 0000", instr_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        reset_and_start();
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== rom[k]) begin failures++; $display("[TB] FAIL stream_word%0d: got valid=%b instr=%h expected 1/%h", k, instr_valid, instr, rom[k]); end
            tick();
        end
        checks++; if (instr_count !== 16'd6) begin failures++; $display("[TB] FAIL stream_count: got %0d expected 6", instr_count); end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        reset_and_start();
        instr_ready = 1'b1;
        tick();
        tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (instr !== rom[2] || rom_addr !== 16'd3 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold%0d: got instr=%h addr=%h valid=%b expected %h/0003/1", k, instr, rom_addr, instr_valid, rom[2]); end
            checks++; if (instr_count !== 16'd2) begin failures++; $display("[TB] FAIL stall_count%0d: got %0d expected 2", k, instr_count); end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (instr !== rom[3] || rom_addr !== 16'd4 || instr_count !== 16'd3) begin failures++; $display("[TB] FAIL stall_resume: got instr=%h addr=%h count=%0d expected %h/0004/3", instr, rom_addr, instr_count, rom[3]); end
    endtask

    task automatic test_branch();
        reset_and_start();
        instr_ready = 1'b1;
        tick();
        branch_valid  = 1'b1;
        branch_target = 16'h0003;
        tick();
        branch_valid  = 1'b0;
        checks++; if (instr_valid !== 1'b0 || busy !== 1'b1 || rom_addr !== 16'h0003) begin failures++; $display("[TB] FAIL branch_bubble: got valid=%b busy=%b addr=%h expected 0/1/0003", instr_valid, busy, rom_addr); end
        checks++; if (instr_count !== 16'd2) begin failures++; $display("[TB] FAIL branch_count: got %0d expected 2", instr_count); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== rom[3] || instr_count !== 16'd2) begin failures++; $display("[TB] FAIL branch_target_word: got valid=%b instr=%h count=%0d expected 1/%h/2", instr_valid, instr, instr_count, rom[3]); end
        instr_ready = 1'b0;
    endtask

    task automatic test_halt_resume();
        rom[4] = halt_word();
        reset_and_start();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== rom[k]) begin failures++; $display("[TB] FAIL halt_pre_word%0d: got valid=%b instr=%h expected 1/%h", k, instr_valid, instr, rom[k]); end
            tick();
        end
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL halt_flags: got halted=%b valid=%b busy=%b expected 1/0/0", halted, instr_valid, busy); end
        checks++; if (rom_addr !== 16'd5 || instr_count !== 16'd4) begin failures++; $display("[TB] FAIL halt_pc_count: got addr=%h count=%0d expected 0005/4", rom_addr, instr_count); end
        branch_valid  = 1'b1;
        branch_target = 16'h0020;
        tick();
        branch_valid  = 1'b0;
        tick();
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 16'd5) begin failures++; $display("[TB] FAIL halt_stays: got halted=%b valid=%b addr=%h expected 1/0/0005", halted, instr_valid, rom_addr); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b0 || rom_addr !== 16'd5) begin failures++; $display("[TB] FAIL resume_fetch: got busy=%b halted=%b valid=%b addr=%h expected 1/0/0/0005", busy, halted, instr_valid, rom_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== rom[5]) begin failures++; $display("[TB] FAIL resume_word: got valid=%b instr=%h expected 1/%h", instr_valid, instr, rom[5]); end
        instr_ready = 1'b0;
        rom[4] = plain_word();
    endtask

    task automatic test_wrap();
        reset_and_start();
        branch_valid  = 1'b1;
        branch_target = 16'hFFFF;
        tick();
        branch_valid  = 1'b0;
        checks++; if (rom_addr !== 16'hFFFF || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_target: got addr=%h valid=%b expected ffff/0", rom_addr, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== rom[65535] || rom_addr !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_last: got valid=%b instr=%h addr=%h expected 1/%h/0000", instr_valid, instr, rom_addr, rom[65535]); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (instr !== rom[0] || rom_addr !== 16'h0001 || instr_count !== 16'd1) begin failures++; $display("[TB] FAIL wrap_first: got instr=%h addr=%h count=%0d expected %h/0001/1", instr, rom_addr, instr_count, rom[0]); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 64; i++) if ($urandom_range(0, 6) == 0) rom[i] = halt_word();
        for (int i = 65472; i < 65536; i++) if ($urandom_range(0, 6) == 0) rom[i] = halt_word();
        reset_and_start();
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom_range(0, 9) == 0);
            instr_ready  = ($urandom_range(0, 9) < 7);
            branch_valid = ($urandom_range(0, 9) == 0);
            r = $urandom;
            branch_target = r[16] ? {10'h3FF, r[5:0]} : {10'h000, r[5:0]};
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
            checks++; if (rom_addr !== m_pc) begin failures++; $display("[TB] FAIL rand_pc@%0d: got %h expected %h", c, rom_addr, m_pc); end
            checks++; if (instr !== m_instr) begin failures++; $display("[TB] FAIL rand_instr@%0d: got %h expected %h", c, instr, m_instr); end
            checks++; if (instr_valid !== m_valid) begin failures++; $display("[TB] FAIL rand_valid@%0d: got %b expected %b", c, instr_valid, m_valid); end
            checks++; if (busy !== m_running) begin failures++; $display("[TB] FAIL rand_busy@%0d: got %b expected %b", c, busy, m_running); end
            checks++; if (halted !== m_halted) begin failures++; $display("[TB] FAIL rand_halted@%0d: got %b expected %b", c, halted, m_halted); end
            checks++; if (instr_count !== m_count) begin failures++; $display("[TB] FAIL rand_count@%0d: got %0d expected %0d", c, instr_count, m_count); end
        end
        start = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0;
        fill_rom();
    endtask

    task automatic test_saturation();
        reset_and_start();
        instr_ready = 1'b1;
        repeat (65534) tick();
        checks++; if (instr_count !== 16'hFFFE) begin failures++; $display("[TB] FAIL sat_before: got %h expected fffe", instr_count); end
        repeat (3) tick();
        checks++; if (instr_count !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_hold: got %h expected ffff", instr_count); end
        checks++; if (instr_valid !== 1'b1 || rom_addr !== m_pc || instr !== m_instr) begin failures++; $display("[TB] FAIL sat_stream: got valid=%b addr=%h instr=%h expected 1/%h/%h", instr_valid, rom_addr, instr, m_pc, m_instr); end
        instr_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        fill_rom();
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_branch();
        test_halt_resume();
        test_wrap();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
